// File: rtl/wb_phase_queue_pkg.sv
// ============================================================================
// Module      : wb_phase_queue_pkg
// Description : Shared definitions for the writeback phase queue: physical
//               register address width and the queued writeback entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_phase_queue_pkg;

    // Physical register file size and the address width derived from it.
    localparam int C_NUM_PR = 64;
    localparam int C_PR_W   = $clog2(C_NUM_PR);

    typedef logic [C_PR_W-1:0] preg_t;

    // One pending register-file write.
    typedef struct packed {
        preg_t       rd;
        logic [31:0] data;
    } wbq_entry_t;

endpackage : wb_phase_queue_pkg

`default_nettype wire

// File: rtl/wb_phase_queue_fifo.sv
// ============================================================================
// Module      : multi_push_fifo
// Description : Circular queue accepting up to NUM_PUSH entries per cycle
//               (packed in ascending push index, no holes) and retiring up to
//               two entries per cycle from the head.
// Ports       : f_clk, reset      - clock, synchronous active-high reset
//               push_valid/data   - per-lane push request and payload
//               pop_cnt           - entries retired this cycle (0..2)
//               head0/head1       - oldest and second-oldest entries
//               count             - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_push_fifo
    import wb_phase_queue_pkg::*;
#(
    parameter int NUM_PUSH = 4,
    parameter int DEPTH    = 8      // power of two, at least 4
) (
    input  logic                         f_clk,
    input  logic                         reset,
    input  logic [NUM_PUSH-1:0]          push_valid,
    input  wbq_entry_t [NUM_PUSH-1:0]    push_data,
    input  logic [1:0]                   pop_cnt,
    output wbq_entry_t                   head0,
    output wbq_entry_t                   head1,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wbq_entry_t      r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic [AW-1:0]   w_slot [NUM_PUSH];
    logic [CW-1:0]   w_push_cnt;

    // Each valid lane lands at write pointer + number of valid lanes below
    // it, so simultaneous pushes pack densely in lane order. Pointer
    // arithmetic is modulo DEPTH because DEPTH is a power of two.
    always_comb begin
        logic [AW-1:0] off;
        logic [CW-1:0] n;
        off = '0;
        n   = '0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            w_slot[i] = r_wr_ptr + off;
            if (push_valid[i]) begin
                off = off + AW'(1);
                n   = n + CW'(1);
            end
        end
        w_push_cnt = n;
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge f_clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PUSH; i++) begin
                if (push_valid[i]) begin
                    r_mem[w_slot[i]] <= push_data[i];
                end
            end
        end
    end

    // The caller guarantees pushes never exceed free space and pops never
    // exceed occupancy, so count stays within 0..DEPTH.
    always_ff @(posedge f_clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(pop_cnt);
            r_wr_ptr <= r_wr_ptr + AW'(w_push_cnt);
            r_count  <= r_count + w_push_cnt - CW'(pop_cnt);
        end
    end

    assign head0 = r_mem[r_rd_ptr];
    assign head1 = r_mem[r_rd_ptr + AW'(1)];
    assign count = r_count;

endmodule : multi_push_fifo

`default_nettype wire

// File: rtl/wb_phase_queue.sv
// ============================================================================
// Module      : wb_phase_queue
// Description : Collects writeback results from NUM_SRC functional units and
//               drains them into a two-write-port register file that runs on
//               a 3x fast clock: phases 0 and 1 are write phases, phase 2 is
//               the read phase.
// Ports       : f_clk, reset         - fast clock, synchronous active-high reset
//               phase_align          - reloads the phase counter to 0
//               src_valid/uses_rd/rd/data - per-source results
//               src_ready            - per-source push permission
//               wr_valid/wr_rd/wr_data - two register-file write ports
//               phase                - current phase (0,1 write; 2 read)
//               stall_cycles         - source stall statistic
// Config      : WBQ_STALL_STATS_EN - when defined, stall_cycles counts cycles
//               with any valid source not ready (saturating); otherwise 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_phase_queue
    import wb_phase_queue_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 8       // power of two, at least 4
) (
    input  logic                            f_clk,
    input  logic                            reset,
    input  logic                            phase_align,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC-1:0]              src_uses_rd,
    input  logic [NUM_SRC-1:0][C_PR_W-1:0]  src_rd,
    input  logic [NUM_SRC-1:0][31:0]        src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic [1:0]                      wr_valid,
    output logic [1:0][C_PR_W-1:0]          wr_rd,
    output logic [1:0][31:0]                wr_data,
    output logic [1:0]                      phase,
    output logic [15:0]                     stall_cycles
);

    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] C_PH_WR0 = 2'd0;
    localparam logic [1:0] C_PH_WR1 = 2'd1;
    localparam logic [1:0] C_PH_RD  = 2'd2;

    logic [1:0]                 r_phase;
    logic [1:0]                 w_phase_next;
    logic                       w_write_phase;

    logic [CW-1:0]              w_count;
    logic [CW-1:0]              w_free;
    logic [NUM_SRC-1:0]         w_push_valid;
    wbq_entry_t [NUM_SRC-1:0]   w_push_data;
    wbq_entry_t                 w_head0;
    wbq_entry_t                 w_head1;
    logic [1:0]                 w_pop_cnt;

    // ------------------------------------------------------------------
    // Phase sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge f_clk) begin
        if (reset) begin
            r_phase <= C_PH_WR0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_phase_next = C_PH_WR0;
        if (!phase_align) begin
            case (r_phase)
                C_PH_WR0: w_phase_next = C_PH_WR1;
                C_PH_WR1: w_phase_next = C_PH_RD;
                default:  w_phase_next = C_PH_WR0;
            endcase
        end
    end

    always_comb begin
        w_write_phase = (r_phase == C_PH_WR0) || (r_phase == C_PH_WR1);
        phase         = r_phase;
    end

    // ------------------------------------------------------------------
    // Push side: readiness comes from registered occupancy only, so slots
    // freed by this cycle's pop become visible next cycle.
    // ------------------------------------------------------------------
    assign w_free = CW'(DEPTH) - w_count;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_ready[i]   = (w_free >= CW'(i + 1));
        assign w_push_data[i] = '{rd: src_rd[i], data: src_data[i]};
    end

    // Results without a destination are accepted but never stored.
    assign w_push_valid = src_valid & src_ready & src_uses_rd;

    multi_push_fifo #(
        .NUM_PUSH (NUM_SRC),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .f_clk      (f_clk),
        .reset      (reset),
        .push_valid (w_push_valid),
        .push_data  (w_push_data),
        .pop_cnt    (w_pop_cnt),
        .head0      (w_head0),
        .head1      (w_head1),
        .count      (w_count)
    );

    // ------------------------------------------------------------------
    // Write side: two ports per write phase, but two writes to the same
    // register in one phase are ambiguous, so the second waits.
    // ------------------------------------------------------------------
    always_comb begin
        wr_valid  = 2'b00;
        w_pop_cnt = 2'd0;
        if (w_write_phase && (w_count >= CW'(1))) begin
            wr_valid[0] = 1'b1;
            w_pop_cnt   = 2'd1;
            if ((w_count >= CW'(2)) && (w_head1.rd != w_head0.rd)) begin
                wr_valid[1] = 1'b1;
                w_pop_cnt   = 2'd2;
            end
        end
    end

    assign wr_rd[0]   = w_head0.rd;
    assign wr_rd[1]   = w_head1.rd;
    assign wr_data[0] = w_head0.data;
    assign wr_data[1] = w_head1.data;

    // ------------------------------------------------------------------
    // Stall statistic
    // ------------------------------------------------------------------
`ifdef WBQ_STALL_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge f_clk) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if ((|(src_valid & ~src_ready)) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule : wb_phase_queue

`default_nettype wire
